hh_spike_decoder: RTL and testbench
===================================

# hh_spike_decoder

Consumes the membrane-potential sample stream produced by the linear Hodgkin-Huxley neuron core and turns it into discrete spike events. It detects threshold crossings with hysteresis and a refractory window, and emits a one-cycle `spike` pulse at each onset. Per spike, it queues an event record (inter-spike interval, peak potential) in a small FIFO for a downstream reader with a valid/ready handshake. It sits between the neuron core's `data_out` and the host/readout logic.

## Interface
Parameters:
- `THRESH_HI`, default 0 — signed mV; onset threshold (v ≥ THRESH_HI).
- `THRESH_LO`, default -50 — signed mV; re-arm level (v ≤ THRESH_LO). Must satisfy THRESH_LO < THRESH_HI.
- `REFRACT`, default 4 — accepted samples that must elapse after a spike ends before re-arming; 0 allowed.
- `FIFO_DEPTH`, default 4 — event FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `v_valid`  in  1  sample strobe; the sample is accepted on any edge where it is high. There is no backpressure toward the neuron.
- `v_in`  in  16  signed membrane potential, integer mV.
- `spike`  out  1  one-cycle onset pulse.
- `armed`  out  1  high while the FSM is in ARMED.
- `evt_valid`  out  1  FIFO head valid.
- `evt_ready`  in  1  reader accepts the head when `evt_valid` and `evt_ready` are both high.
- `evt_isi`  out  16  unsigned ISI of the head event, in accepted samples, saturating at 0xFFFF.
- `evt_peak`  out  16  signed peak v_in of the head event.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full. Cleared only by reset.

## Operation
- FSM states and transitions. Each transition is evaluated only on accepted samples; state holds when `v_valid` is low.
  - IDLE → ARMED when v ≤ THRESH_LO. This suppresses false onsets if the stream starts depolarised.
  - ARMED → ABOVE when v ≥ THRESH_HI (onset).
    - Pulse `spike`.
    - Latch `isi = sat16(cnt+1)`, then set `cnt ← 0`.
    - Set `peak ← v`.
  - ABOVE:
    - While v ≥ THRESH_HI: `peak ← max(peak, v)` (signed compare).
    - When v < THRESH_HI: push {isi, peak} to the FIFO, load `rcnt ← REFRACT`, and go to REFRACT.
  - REFRACT, per accepted sample:
    - If rcnt ≠ 0: decrement rcnt.
    - Else if v ≤ THRESH_LO: go to ARMED.
    - Samples ≥ THRESH_HI in REFRACT never produce a spike.
- ISI counter `cnt`:
  - Increments (saturating at 0xFFFF) on every accepted sample except an onset sample.
  - Reset value is 0, so the first event's ISI equals the 1-based index of its onset sample since reset.
  - The ISI recorded is the number of accepted samples between consecutive onsets.
- All threshold and peak comparisons are 16-bit signed. The ISI saturates and never wraps.
- FIFO behaviour:
  - If a push occurs while the FIFO is full and no pop happens on the same edge, the new event is dropped and `overflow` is set.
  - A push and a pop on the same edge while full are both performed, and occupancy is unchanged.
  - Read order is FIFO. The head is stable while `evt_valid` is high and `evt_ready` is low.
- Reset (including mid-spike):
  - State → IDLE; cnt, rcnt, and peak → 0; FIFO is emptied; `overflow` → 0.
  - Any in-progress spike is discarded and no event is pushed.

## Timing
- Reset values: `spike`=0, `armed`=0, `evt_valid`=0, `evt_isi`=0, `evt_peak`=0, `overflow`=0.
- `spike` is high for exactly the one cycle following the edge that accepts the onset sample.
- The event push happens on the edge that accepts the falling sample. `evt_valid` rises in the next cycle if the FIFO was empty, giving a latency of 1 cycle.
- A pop on edge k presents the next entry, or drops `evt_valid`, in the cycle after edge k.
- Consecutive accepted samples are supported with no required gaps. Throughput is 1 sample per cycle.

## Structure
- Shared package `hh_pkg` holds:
  - the `V_W`=16 width constant;
  - the FSM state enum (IDLE, ARMED, ABOVE, REFRACT);
  - the default threshold constants;
  - the event record type {isi[15:0], peak[15:0]}, which is 32 bits.
- Sub-module `hh_evt_fifo`: synchronous FIFO with parameters `WIDTH`=32 and `DEPTH`. It exposes push, pop, full, empty, and head. The overflow/drop logic stays in the parent.

## Test plan
- **Basic spike, defaults.**
  - Stimulus: samples -65, -40, -10, 5, 30, 12, -20, -70, one per cycle.
  - Required: `spike` high in the cycle after the sample 5 is accepted. One event with isi=4 and peak=30, with `evt_valid` high in the cycle after -20 is accepted.
- **ISI measurement.**
  - Stimulus: two onsets 20 accepted samples apart, with 3 `v_valid`=0 cycles inserted between them.
  - Required: second event isi=20.
- **Refractory window, REFRACT=4.**
  - Stimulus: after a spike ends, send -60, 10, -60, -60, then -60, then 10.
  - Required: the first 10 produces no spike. The fifth sample arms the FSM, and the final 10 spikes.
- **IDLE hysteresis.**
  - Stimulus: after reset, send 10, 20, -30, then 10.
  - Required: no spike.
  - Stimulus: then send -55, then 10.
  - Required: a spike.
- **FIFO overflow, DEPTH=4.**
  - Stimulus: hold `evt_ready`=0 through 5 complete spikes, then drain.
  - Required: `overflow`=1 and 4 events retained, read back in order with the 5th missing.
  - Stimulus: a simultaneous push and pop while full.
  - Required: nothing is lost.
- **Reset mid-spike.**
  - Stimulus: assert `reset` for 1 cycle while in ABOVE with one event queued.
  - Required: all outputs return to 0, no event appears, and the next spike reports isi counted from reset.

Source files
------------

// File: rtl/hh_pkg.sv
// Shared types and constants for the Hodgkin-Huxley spike decoder.
package hh_pkg;

  localparam int unsigned V_W = 16;

  // Default thresholds in signed mV.
  localparam int THRESH_HI_DEF = 0;
  localparam int THRESH_LO_DEF = -50;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StAbove,
    StRefract
  } hh_state_e;

  // One queued spike event: inter-spike interval and peak potential.
  typedef struct packed {
    logic        [15:0] isi;
    logic signed [15:0] peak;
  } hh_evt_t;

  // Saturating 16-bit increment; the ISI must never wrap.
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/hh_evt_fifo.sv
// Small synchronous FIFO for spike event records. Push while full is only
// performed when a pop happens on the same edge; drop policy lives in the parent.
module hh_evt_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents need no reset since the head is qualified by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Read/write pointer update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/hh_spike_decoder.sv
// Turns a membrane-potential sample stream into spike pulses and queued
// {ISI, peak} event records, using hysteresis plus a refractory window.
module hh_spike_decoder
  import hh_pkg::*;
#(
  parameter int          THRESH_HI  = THRESH_HI_DEF,
  parameter int          THRESH_LO  = THRESH_LO_DEF,
  parameter int unsigned REFRACT    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  v_valid,
  input  logic signed [V_W-1:0] v_in,
  output logic                  spike,
  output logic                  armed,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic        [V_W-1:0] evt_isi,
  output logic signed [V_W-1:0] evt_peak,
  output logic                  overflow
);

  localparam logic signed [V_W-1:0] ThHi       = V_W'(THRESH_HI);
  localparam logic signed [V_W-1:0] ThLo       = V_W'(THRESH_LO);
  localparam logic        [15:0]    RefractVal = 16'(REFRACT);

  hh_state_e                state_q;
  logic        [15:0]       cnt_q;
  logic        [15:0]       rcnt_q;
  logic        [15:0]       isi_q;
  logic signed [V_W-1:0]    peak_q;
  logic                     spike_q;
  logic                     overflow_q;

  logic    ge_hi, le_lo, onset, fall, pop, drop;
  logic    fifo_full, fifo_empty;
  hh_evt_t push_rec, head;

  assign ge_hi = (v_in >= ThHi);
  assign le_lo = (v_in <= ThLo);
  assign onset = v_valid && (state_q == StArmed) && ge_hi;
  // The sample that ends a spike is the one that pushes its record.
  assign fall  = v_valid && (state_q == StAbove) && !ge_hi;
  assign pop   = evt_ready && !fifo_empty;
  assign drop  = fall && fifo_full && !pop;

  assign push_rec = '{isi: isi_q, peak: peak_q};

  hh_evt_fifo #(
    .WIDTH($bits(hh_evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (fall),
    .data_i (push_rec),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  // Detector FSM, ISI/refractory counters and registered pulse/sticky outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      isi_q      <= '0;
      peak_q     <= '0;
      spike_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      spike_q <= onset;
      if (drop) overflow_q <= 1'b1;
      if (v_valid) begin
        cnt_q <= onset ? 16'd0 : sat_inc16(cnt_q);
        unique case (state_q)
          StIdle: begin
            if (le_lo) state_q <= StArmed;
          end
          StArmed: begin
            if (ge_hi) begin
              state_q <= StAbove;
              isi_q   <= sat_inc16(cnt_q);
              peak_q  <= v_in;
            end
          end
          StAbove: begin
            if (ge_hi) begin
              if (v_in > peak_q) peak_q <= v_in;
            end else begin
              rcnt_q  <= RefractVal;
              state_q <= StRefract;
            end
          end
          StRefract: begin
            if (rcnt_q != 16'd0) begin
              rcnt_q <= rcnt_q - 16'd1;
            end else if (le_lo) begin
              state_q <= StArmed;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign spike     = spike_q;
  assign armed     = (state_q == StArmed);
  assign overflow  = overflow_q;
  assign evt_valid = !fifo_empty;
  // Hold the head at zero when nothing is queued so stale entries stay hidden.
  assign evt_isi   = fifo_empty ? '0 : head.isi;
  assign evt_peak  = fifo_empty ? '0 : head.peak;

endmodule

// File: tb/tb_hh_spike_decoder.sv
// Self-checking bench for hh_spike_decoder with an expected-event scoreboard.
module tb_hh_spike_decoder;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               v_valid = 1'b0;
  logic signed [15:0] v_in = '0;
  logic               spike, armed, evt_valid, overflow;
  logic               evt_ready = 1'b0;
  logic        [15:0] evt_isi;
  logic signed [15:0] evt_peak;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  hh_spike_decoder #(
    .THRESH_HI (0),
    .THRESH_LO (-50),
    .REFRACT   (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .v_valid  (v_valid),
    .v_in     (v_in),
    .spike    (spike),
    .armed    (armed),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_isi  (evt_isi),
    .evt_peak (evt_peak),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one accepted sample and check the spike pulse right after its edge.
  task automatic send(input logic signed [15:0] v, input logic exp_spike, input string tag);
    @(negedge clk);
    v_valid = 1'b1;
    v_in    = v;
    @(posedge clk);
    #1;
    n_tests++;
    if (spike !== exp_spike) begin
      n_fail++;
      $display("FAIL %s: spike=%b expected %b (v=%0d)", tag, spike, exp_spike, v);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      v_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    v_valid   = 1'b0;
    evt_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pop everything from the DUT, comparing each head against the scoreboard.
  task automatic drain(input string tag);
    logic [31:0] e;
    gap(1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      evt_ready = 1'b1;
      if (!evt_valid) break;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected event: isi=%0d peak=%0d, expected none",
                 tag, evt_isi, evt_peak);
      end else begin
        e = exp_q.pop_front();
        if ({evt_isi, evt_peak} !== e) begin
          n_fail++;
          $display("FAIL %s event: isi=%0d peak=%0d, expected isi=%0d peak=%0d",
                   tag, evt_isi, evt_peak, e[31:16], $signed(e[15:0]));
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    evt_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing events: got %0d left over, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({spike, armed, evt_valid, evt_isi, evt_peak, overflow} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_values: spike=%b armed=%b evt_valid=%b isi=%0d peak=%0d ovf=%b, expected all 0",
               spike, armed, evt_valid, evt_isi, evt_peak, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    send(-65, 0, "basic");
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_armed: armed=%b expected 1", armed);
    end
    send(-40, 0, "basic");
    send(-10, 0, "basic");
    send(5, 1, "basic_onset");
    exp_q.push_back({16'd4, 16'sd30});
    send(30, 0, "basic");
    send(12, 0, "basic");
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: evt_valid=%b expected 0", evt_valid);
    end
    send(-20, 0, "basic_fall");
    n_tests++;
    if (evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid_latency: evt_valid=%b expected 1", evt_valid);
    end
    send(-70, 0, "basic");
    drain("basic");
  endtask

  task automatic test_isi();
    do_reset();
    send(-60, 0, "isi");
    send(10, 1, "isi_onset1");
    exp_q.push_back({16'd2, 16'sd10});
    send(-60, 0, "isi_fall1");
    repeat (5) send(-60, 0, "isi_wait");
    repeat (6) send(-60, 0, "isi_wait");
    gap(3);
    repeat (7) send(-60, 0, "isi_wait");
    send(10, 1, "isi_onset2");
    exp_q.push_back({16'd20, 16'sd10});
    send(-60, 0, "isi_fall2");
    drain("isi");
  endtask

  task automatic test_refractory();
    do_reset();
    send(-60, 0, "refr");
    send(5, 1, "refr_onset1");
    exp_q.push_back({16'd2, 16'sd5});
    send(-60, 0, "refr_fall");
    send(-60, 0, "refr");
    send(10, 0, "refr_blocked");
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL refr_not_armed: armed=%b expected 0", armed);
    end
    send(-60, 0, "refr");
    send(-60, 0, "refr");
    send(-60, 0, "refr_rearm");
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL refr_rearmed: armed=%b expected 1", armed);
    end
    send(10, 1, "refr_onset2");
    exp_q.push_back({16'd7, 16'sd10});
    send(-60, 0, "refr_fall2");
    drain("refr");
  endtask

  task automatic test_idle_hysteresis();
    do_reset();
    send(10, 0, "idle");
    send(20, 0, "idle");
    send(-30, 0, "idle");
    send(10, 0, "idle");
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_not_armed: armed=%b expected 0", armed);
    end
    send(-55, 0, "idle_arm");
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_armed: armed=%b expected 1", armed);
    end
    send(10, 1, "idle_onset");
    exp_q.push_back({16'd6, 16'sd10});
    send(-60, 0, "idle_fall");
    drain("idle");
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    logic signed [15:0] pk;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pk = 16'(11 + 10 * i);
      send(-60, 0, "ovf_arm");
      send(pk, 1, "ovf_onset");
      if (i < 4) exp_q.push_back({(i == 0) ? 16'd2 : 16'd7, pk});
      send(-60, 0, "ovf_fall");
      if (i >= 3) begin
        n_tests++;
        if (overflow !== (i == 4)) begin
          n_fail++;
          $display("FAIL ovf_flag_%0d: overflow=%b expected %b", i, overflow, (i == 4));
        end
      end
      repeat (4) send(-60, 0, "ovf_refr");
    end
    // Sixth spike ends on the same edge that pops the oldest entry.
    send(-60, 0, "ovf_arm6");
    send(61, 1, "ovf_onset6");
    exp_q.push_back({16'd7, 16'sd61});
    @(negedge clk);
    v_valid   = 1'b1;
    v_in      = -60;
    evt_ready = 1'b1;
    e = exp_q.pop_front();
    n_tests++;
    if ({evt_valid, evt_isi, evt_peak} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL ovf_head_at_pushpop: valid=%b isi=%0d peak=%0d, expected valid=1 isi=%0d peak=%0d",
               evt_valid, evt_isi, evt_peak, e[31:16], $signed(e[15:0]));
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({spike, overflow} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_sticky: spike=%b overflow=%b, expected spike=0 overflow=1",
               spike, overflow);
    end
    @(negedge clk);
    evt_ready = 1'b0;
    v_valid   = 1'b0;
    drain("ovf");
  endtask

  task automatic test_reset_mid_spike();
    repeat (5) send(-60, 0, "mid_prep");
    send(10, 1, "mid_onset1");
    send(-60, 0, "mid_fall1");
    n_tests++;
    if (evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_queued: evt_valid=%b expected 1", evt_valid);
    end
    repeat (5) send(-60, 0, "mid_prep");
    send(20, 1, "mid_onset2");
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ovf_before: overflow=%b expected 1", overflow);
    end
    @(negedge clk);
    reset   = 1'b1;
    v_valid = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({spike, armed, evt_valid, evt_isi, evt_peak, overflow} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values: spike=%b armed=%b evt_valid=%b isi=%0d peak=%0d ovf=%b, expected all 0",
               spike, armed, evt_valid, evt_isi, evt_peak, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    gap(2);
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_event: evt_valid=%b expected 0", evt_valid);
    end
    send(-60, 0, "mid_after");
    send(-55, 0, "mid_after");
    send(15, 1, "mid_onset3");
    exp_q.push_back({16'd3, 16'sd15});
    send(-60, 0, "mid_fall3");
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_isi();
    test_refractory();
    test_idle_hysteresis();
    test_overflow();
    test_reset_mid_spike();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
